// File: rtl/y86_fetch_stage_if.sv
// Y86 fetch stage bus: byte-wide imem read port, redirect input
// and the valid/ready bundle presented to decode.
interface y86_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        f_valid;
  logic        d_ready;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [31:0] f_valC;
  logic [31:0] f_valP;
  logic [1:0]  f_stat;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata, imem_err,
    input  pc_redirect, pc_target, d_ready,
    output f_valid, f_icode, f_ifun, f_rA, f_rB,
    output f_valC, f_valP, f_stat
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata, imem_err,
    output pc_redirect, pc_target, d_ready,
    input  f_valid, f_icode, f_ifun, f_rA, f_rB,
    input  f_valC, f_valP, f_stat
  );
endinterface

// File: rtl/y86_fetch_stage.sv
// Y86-32 fetch stage: byte-serial instruction fetch with one
// outstanding request and a single-entry output to decode.
module y86_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  y86_fetch_stage_if.master bus
);

  typedef enum logic [2:0] {
    S_B0, S_B1, S_C, S_OUT, S_STOP
  } state_t;

  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  state_t      state;
  logic [31:0] pc;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [31:0] valc;
  logic [31:0] valp;
  logic [1:0]  stat;
  logic [1:0]  k;
  logic        pend;
  logic [31:0] pend_tgt;

  logic        redir;
  logic [31:0] tgt;
  logic        fetch;
  logic [3:0]  hi;
  logic [3:0]  lo;
  logic [31:0] c_off;
  logic [31:0] req_addr;
  logic [31:0] len;

  function automatic logic [31:0] ilen(
    input logic [3:0] ic
  );
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: ilen = 32'd2;
      4'h7, 4'h8:             ilen = 32'd5;
      4'h3, 4'h4, 4'h5:       ilen = 32'd6;
      default:                ilen = 32'd1;
    endcase
  endfunction

  // A redirect pulse this cycle wins over an older pending one
  assign redir = bus.pc_redirect | pend;
  assign tgt   = bus.pc_redirect ? bus.pc_target
                                 : pend_tgt;
  assign fetch = (state == S_B0) || (state == S_B1)
              || (state == S_C);
  assign hi    = bus.imem_rdata[7:4];
  assign lo    = bus.imem_rdata[3:0];
  assign len   = ilen(hi);
  assign c_off = (icode == 4'h7 || icode == 4'h8)
               ? 32'd1 : 32'd2;

  always_comb begin
    req_addr = pc;
    unique case (state)
      S_B1:    req_addr = pc + 32'd1;
      S_C:     req_addr = pc + c_off + {30'd0, k};
      default: req_addr = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_B0;
      pc       <= RESET_PC;
      req      <= 1'b0;
      addr     <= 32'd0;
      valid    <= 1'b0;
      icode    <= 4'h0;
      ifun     <= 4'h0;
      ra       <= 4'hF;
      rb       <= 4'hF;
      valc     <= 32'd0;
      valp     <= 32'd0;
      stat     <= AOK;
      k        <= 2'd0;
      pend     <= 1'b0;
      pend_tgt <= 32'd0;
    end else begin
      if (bus.pc_redirect) begin
        pend     <= 1'b1;
        pend_tgt <= bus.pc_target;
      end
      if (fetch) begin
        if (!req) begin
          if (redir) begin
            pc    <= tgt;
            pend  <= 1'b0;
            state <= S_B0;
          end else begin
            req  <= 1'b1;
            addr <= req_addr;
          end
        end else if (bus.imem_ack) begin
          req <= 1'b0;
          if (redir) begin
            pc    <= tgt;
            pend  <= 1'b0;
            state <= S_B0;
          end else begin
            unique case (state)
              S_B0: begin
                icode <= bus.imem_err ? 4'h0 : hi;
                ifun  <= bus.imem_err ? 4'h0 : lo;
                ra    <= 4'hF;
                rb    <= 4'hF;
                valc  <= 32'd0;
                valp  <= pc + len;
                k     <= 2'd0;
                if (bus.imem_err) begin
                  stat  <= ADR;
                  valid <= 1'b1;
                  state <= S_OUT;
                end else if (hi > 4'hB) begin
                  stat  <= INS;
                  valid <= 1'b1;
                  state <= S_OUT;
                end else if (len == 32'd1) begin
                  stat  <= (hi == 4'h0) ? HLT : AOK;
                  valid <= 1'b1;
                  state <= S_OUT;
                end else begin
                  stat  <= AOK;
                  state <= (len == 32'd5) ? S_C : S_B1;
                end
              end
              S_B1: begin
                if (bus.imem_err) begin
                  stat  <= ADR;
                  valid <= 1'b1;
                  state <= S_OUT;
                end else begin
                  ra <= hi;
                  rb <= lo;
                  if (icode == 4'h3 || icode == 4'h4
                      || icode == 4'h5) begin
                    state <= S_C;
                  end else begin
                    valid <= 1'b1;
                    state <= S_OUT;
                  end
                end
              end
              S_C: begin
                if (bus.imem_err) begin
                  stat  <= ADR;
                  valid <= 1'b1;
                  state <= S_OUT;
                end else begin
                  valc[{k, 3'b000} +: 8] <= bus.imem_rdata;
                  k <= k + 2'd1;
                  if (k == 2'd3) begin
                    valid <= 1'b1;
                    state <= S_OUT;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end else if (state == S_OUT) begin
        if (bus.d_ready) begin
          valid <= 1'b0;
          if (redir) begin
            pc    <= tgt;
            pend  <= 1'b0;
            state <= S_B0;
          end else begin
            pc    <= valp;
            state <= (stat == AOK) ? S_B0 : S_STOP;
          end
        end else if (redir) begin
          valid <= 1'b0;
          pc    <= tgt;
          pend  <= 1'b0;
          state <= S_B0;
        end
      end else if (redir) begin
        pc    <= tgt;
        pend  <= 1'b0;
        state <= S_B0;
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.f_valid   = valid;
  assign bus.f_icode   = icode;
  assign bus.f_ifun    = ifun;
  assign bus.f_rA      = ra;
  assign bus.f_rB      = rb;
  assign bus.f_valC    = valc;
  assign bus.f_valP    = valp;
  assign bus.f_stat    = stat;

endmodule
